sobel_frame_ctrl: RTL and testbench

//  Frame sequencer for the grayscale->padder->sobel pipeline. On start, streams IMG_WIDTH*IMG_HEIGHT
//  RGB pixels from a sync-read RGB memory into the pipeline's RGB input FIFO and drains the same

---
 rtl/sobel_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the grayscale->padder->sobel pipeline: streams one RGB frame from memory
// into the pipeline input FIFO and drains the same number of sobel results back to memory.
module sobel_frame_ctrl #(
  parameter int IMG_WIDTH    = 720,
  parameter int IMG_HEIGHT   = 540,
  parameter int RGB_DWIDTH   = 24,
  parameter int SOBEL_DWIDTH = 8,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             frame_cycles,
  output logic                    rgb_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   rgb_mem_rd_addr,
  input  logic [RGB_DWIDTH-1:0]   rgb_mem_rd_data,
  output logic                    fifo_rgb_wr_en,
  output logic [RGB_DWIDTH-1:0]   fifo_rgb_din,
  input  logic                    fifo_rgb_full,
  output logic                    fifo_sobel_rd_en,
  input  logic [SOBEL_DWIDTH-1:0] fifo_sobel_dout,
  input  logic                    fifo_sobel_empty,
  output logic                    sobel_mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   sobel_mem_wr_addr,
  output logic [SOBEL_DWIDTH-1:0] sobel_mem_wr_data,
  output logic [1:0]              dbg_state
);

  localparam int N  = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C = CW'(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Handshakes: every strobe is a single-cycle transfer. A FIFO write happens in any cycle where
  // fifo_rgb_wr_en is high (never while full); a sobel FIFO read returns data the next cycle.
  logic [1:0]            state;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         drn_cnt;
  logic [CW-1:0]         wr_cnt;
  logic                  in_flight;
  logic                  wr_pend;
  logic [1:0]            skid_cnt;
  logic [RGB_DWIDTH-1:0] skid0;
  logic [RGB_DWIDTH-1:0] skid1;

  logic       run;
  logic       accept;
  logic       skid_pop;
  logic       skid_push;
  logic [2:0] occ;
  logic       feed_rd;
  logic       drain_rd;

  always_comb begin
    run       = (state == S_RUN);
    accept    = (state == S_IDLE) && start;
    skid_pop  = run && (skid_cnt != 2'd0) && !fifo_rgb_full;
    skid_push = run && in_flight;
    // A pop in this cycle frees its slot now, which keeps the read stream at one per cycle.
    occ       = {1'b0, skid_cnt} + {2'b00, in_flight} - {2'b00, skid_pop};
    feed_rd   = run && (rd_cnt < N_C) && (occ < 3'd2);
    drain_rd  = run && !fifo_sobel_empty && (drn_cnt < N_C);
  end

  assign busy              = run;
  assign done              = (state == S_DONE);
  assign dbg_state         = state;
  assign rgb_mem_rd_en     = feed_rd;
  assign rgb_mem_rd_addr   = ADDR_WIDTH'(rd_cnt);
  assign fifo_rgb_wr_en    = skid_pop;
  assign fifo_rgb_din      = skid0;
  assign fifo_sobel_rd_en  = drain_rd;
  assign sobel_mem_wr_en   = wr_pend;
  assign sobel_mem_wr_addr = ADDR_WIDTH'(wr_cnt);
  assign sobel_mem_wr_data = wr_pend ? fifo_sobel_dout : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      frame_cycles <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_RUN;
            frame_cycles <= '0;
          end
        end
        S_RUN: begin
          if (frame_cycles != '1) frame_cycles <= frame_cycles + 32'd1;
          if ((wr_cnt == N_C) && !wr_pend) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_cnt    <= '0;
      drn_cnt   <= '0;
      wr_cnt    <= '0;
      in_flight <= 1'b0;
      wr_pend   <= 1'b0;
      skid_cnt  <= 2'd0;
      skid0     <= '0;
      skid1     <= '0;
    end else if (accept) begin
      rd_cnt    <= '0;
      drn_cnt   <= '0;
      wr_cnt    <= '0;
      in_flight <= 1'b0;
      wr_pend   <= 1'b0;
      skid_cnt  <= 2'd0;
      skid0     <= '0;
      skid1     <= '0;
    end else begin
      in_flight <= feed_rd;
      wr_pend   <= drain_rd;
      if (feed_rd)  rd_cnt  <= rd_cnt + CW'(1);
      if (drain_rd) drn_cnt <= drn_cnt + CW'(1);
      if (wr_pend)  wr_cnt  <= wr_cnt + CW'(1);
      // skid0 is always the head; skid1 only holds data while two entries are present.
      case ({skid_push, skid_pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= rgb_mem_rd_data;
          else                  skid1 <= rgb_mem_rd_data;
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= rgb_mem_rd_data;
          end else begin
            skid0 <= skid1;
            skid1 <= rgb_mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl on a 4x3 frame: memory and FIFO models, a negedge monitor that
// pops expected queues, and directed frame scenarios (reset, backpressure, starvation, restart).
module tb_sobel_frame_ctrl;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;
  localparam int RW = 24;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [31:0]   frame_cycles;
  logic          rgb_mem_rd_en;
  logic [AW-1:0] rgb_mem_rd_addr;
  logic [RW-1:0] rgb_mem_rd_data = '0;
  logic          fifo_rgb_wr_en;
  logic [RW-1:0] fifo_rgb_din;
  logic          fifo_rgb_full = 1'b0;
  logic          fifo_sobel_rd_en;
  logic [SW-1:0] fifo_sobel_dout = '0;
  logic          fifo_sobel_empty = 1'b1;
  logic          sobel_mem_wr_en;
  logic [AW-1:0] sobel_mem_wr_addr;
  logic [SW-1:0] sobel_mem_wr_data;
  logic [1:0]    dbg_state;

  sobel_frame_ctrl #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .RGB_DWIDTH(RW), .SOBEL_DWIDTH(SW), .ADDR_WIDTH(AW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .frame_cycles(frame_cycles),
    .rgb_mem_rd_en(rgb_mem_rd_en), .rgb_mem_rd_addr(rgb_mem_rd_addr),
    .rgb_mem_rd_data(rgb_mem_rd_data),
    .fifo_rgb_wr_en(fifo_rgb_wr_en), .fifo_rgb_din(fifo_rgb_din), .fifo_rgb_full(fifo_rgb_full),
    .fifo_sobel_rd_en(fifo_sobel_rd_en), .fifo_sobel_dout(fifo_sobel_dout),
    .fifo_sobel_empty(fifo_sobel_empty),
    .sobel_mem_wr_en(sobel_mem_wr_en), .sobel_mem_wr_addr(sobel_mem_wr_addr),
    .sobel_mem_wr_data(sobel_mem_wr_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- models ----------------
  logic [RW-1:0] rgb_mem [0:15];
  logic [SW-1:0] sobel_q[$];
  bit force_empty = 1'b0;
  bit starve_rand = 1'b0;

  always @(posedge clock) begin
    if (rgb_mem_rd_en) rgb_mem_rd_data <= rgb_mem[rgb_mem_rd_addr];
  end

  always @(posedge clock) begin
    if (fifo_sobel_rd_en && (sobel_q.size() > 0)) fifo_sobel_dout <= sobel_q.pop_front();
    #2;
    fifo_sobel_empty = force_empty || (starve_rand && ($urandom_range(0, 1) == 1)) ||
                       (sobel_q.size() == 0);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [RW-1:0]    exp_rgb_q[$];
  logic [AW+SW-1:0] exp_wr_q[$];
  int rd_seen = 0, pop_seen = 0, done_cnt = 0, cyc = 0;
  int rd_first_cyc = 0, rd_last_cyc = 0;
  int rd_base = 0, out_base = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  always @(negedge clock) begin
    int outstanding;
    cyc++;
    if (rgb_mem_rd_en) begin
      check("rd_addr", 128'(rgb_mem_rd_addr), 128'(rd_seen - rd_base));
      if (rd_seen - rd_base == 0)     rd_first_cyc = cyc;
      if (rd_seen - rd_base == N - 1) rd_last_cyc = cyc;
      rd_seen++;
    end
    if (fifo_rgb_wr_en) begin
      check("rgb_wr_while_full", 128'(fifo_rgb_full), 128'(0));
      if (exp_rgb_q.size() == 0) fail_now("rgb_extra_pixel");
      else check("rgb_din", 128'(fifo_rgb_din), 128'(exp_rgb_q.pop_front()));
      pop_seen++;
    end
    if (rgb_mem_rd_en || fifo_rgb_wr_en) begin
      outstanding = rd_seen - pop_seen - out_base;
      check("outstanding_le2", 128'(outstanding <= 2), 128'(1));
    end
    if (fifo_sobel_rd_en) check("sobel_rd_when_empty", 128'(fifo_sobel_empty), 128'(0));
    if (sobel_mem_wr_en) begin
      if (exp_wr_q.size() == 0) fail_now("sobel_extra_write");
      else check("sobel_wr", 128'({sobel_mem_wr_addr, sobel_mem_wr_data}),
                 128'(exp_wr_q.pop_front()));
    end
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic check_zero(input string name);
    check(name, {rgb_mem_rd_en, rgb_mem_rd_addr, fifo_rgb_wr_en, fifo_rgb_din, fifo_sobel_rd_en,
                 sobel_mem_wr_en, sobel_mem_wr_addr, sobel_mem_wr_data, busy, done,
                 frame_cycles, dbg_state}, 128'(0));
  endtask

  // Called at posedge+1; loads expectations and the sobel FIFO, then pulses start.
  task automatic start_frame(input int n_sobel, input int seed);
    logic [SW-1:0] sv;
    sobel_q.delete();
    exp_rgb_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < n_sobel; i++) begin
      sv = SW'(8'h30 + i * 7 + seed * 3);
      sobel_q.push_back(sv);
      if (i < N) exp_wr_q.push_back({AW'(i), sv});
    end
    for (int i = 0; i < N; i++) exp_rgb_q.push_back(rgb_mem[i]);
    rd_base  = rd_seen;
    out_base = rd_seen - pop_seen;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit chk_fc, input logic [31:0] exp_fc,
                           input bit start_in_done);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      fail_now({tag, "_done_timeout"});
    end else begin
      check({tag, "_busy_at_done"}, 128'(busy), 128'(0));
      if (chk_fc) check({tag, "_frame_cycles"}, 128'(frame_cycles), 128'(exp_fc));
      check({tag, "_rgb_left"}, 128'(exp_rgb_q.size()), 128'(0));
      check({tag, "_wr_left"}, 128'(exp_wr_q.size()), 128'(0));
      if (start_in_done) start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(negedge clock);
      check({tag, "_done_one_cycle"}, 128'(done), 128'(0));
      check({tag, "_busy_after"}, 128'(busy), 128'(0));
      check({tag, "_done_pulses"}, 128'(done_cnt - d0), 128'(1));
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit hit;
    int d0;
    for (int i = 0; i < 16; i++) rgb_mem[i] = RW'(24'hA00000 + (i + 1) * 24'h010203);

    // 1: reset held, start toggled
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1 start = (i % 2 == 0);
      @(negedge clock);
      check_zero("reset_hold_outputs");
    end
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // 2: small frame, no stalls
    start_frame(N, 0);
    wait_done("basic", 1'b1, 32'd14, 1'b0);
    check("basic_consecutive_reads", 128'(rd_last_cyc - rd_first_cyc), 128'(N - 1));

    // 3: RGB FIFO full for 10 cycles mid-frame, drain held off a little longer
    @(posedge clock);
    #1 start_frame(N, 1);
    repeat (4) @(posedge clock);
    #1 begin
      fifo_rgb_full = 1'b1;
      force_empty   = 1'b1;
    end
    repeat (10) @(posedge clock);
    #1 fifo_rgb_full = 1'b0;
    repeat (6) @(posedge clock);
    #1 force_empty = 1'b0;
    wait_done("backpressure", 1'b0, 32'd0, 1'b0);

    // 4: starved drain, extra words left in the sobel FIFO
    @(posedge clock);
    #1 starve_rand = 1'b1;
    start_frame(N + 3, 2);
    wait_done("starve", 1'b0, 32'd0, 1'b0);
    starve_rand = 1'b0;
    check("starve_extra_unread", 128'(sobel_q.size()), 128'(3));

    // 5: start during RUN and DONE ignored, then a second frame reloads frame_cycles
    @(posedge clock);
    #1 start_frame(N, 3);
    repeat (4) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done("restart_a", 1'b1, 32'd14, 1'b1);
    @(posedge clock);
    #1 start_frame(N, 4);
    wait_done("restart_b", 1'b1, 32'd14, 1'b0);

    // 6: asynchronous reset at pixel 5, then a clean restart
    @(posedge clock);
    #1 start_frame(N, 5);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clock);
      if (rgb_mem_rd_en && (rgb_mem_rd_addr == AW'(5))) hit = 1'b1;
    end
    if (!hit) fail_now("midreset_pixel5_timeout");
    reset = 1'b0;
    #1 check_zero("midreset_outputs");
    d0 = done_cnt;
    repeat (3) @(negedge clock);
    check("midreset_no_done", 128'(done_cnt - d0), 128'(0));
    reset = 1'b1;
    @(posedge clock);
    #1 start_frame(N, 6);
    wait_done("after_reset", 1'b1, 32'd14, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
